// File: rtl/z80_io_mailbox.sv
// z80_io_mailbox: Z80 I/O-space byte mailbox between the CPU and an external host.
//   clk, reset                    system clock, synchronous active-high reset
//   iorq_n, m1_n, rd_n, wr_n      Z80 bus strobes (interrupt acknowledge is never decoded)
//   addr, wr_data                 Z80 A[7:0] and CPU data out
//   rd_data, doe                  read data and drive-enable for the shared di bus
//   tx_valid, tx_ready, tx_data   TX FIFO stream towards the host
//   rx_valid, rx_ready, rx_data   RX FIFO stream from the host
//   int_n                         active-low interrupt, real only when MAILBOX_INT_EN is defined
// Registers at BASE_ADDR+0..3: DATA, STATUS, CTRL, LEVEL.
module z80_io_mailbox #(
    parameter logic [7:0] BASE_ADDR  = 8'h20,
    parameter int         DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       doe,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       int_n
);
    localparam int W = DEPTH_LOG2 + 1;
    localparam int D = 1 << DEPTH_LOG2;
    logic [7:0] tx_mem [D];
    logic [7:0] rx_mem [D];
    logic [W-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_cnt, rx_cnt;
    logic [1:0] off;
    logic [7:0] rx_head, status, level;
    logic acc, acc_q, rd0_q, wr_ev, ctrl_wr, int_en, tx_ovf, rx_udf;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop_ev, rx_pop;

    function automatic logic [3:0] sat4(input logic [W-1:0] c);
        return (32'(c) > 32'd15) ? 4'hF : 4'(c);
    endfunction

    always_comb begin
        off       = addr[1:0];
        acc       = !iorq_n && m1_n && (addr[7:2] == BASE_ADDR[7:2]) && (!rd_n || !wr_n);
        doe       = acc && !rd_n;
        // Writes act only on the leading clk of an access, so wait states never repeat them.
        wr_ev     = acc && !wr_n && !acc_q;
        ctrl_wr   = wr_ev && off == 2'd2;
        tx_empty  = tx_wp == tx_rp;
        tx_full   = tx_wp[DEPTH_LOG2] != tx_rp[DEPTH_LOG2] &&
                    tx_wp[DEPTH_LOG2-1:0] == tx_rp[DEPTH_LOG2-1:0];
        rx_empty  = rx_wp == rx_rp;
        rx_full   = rx_wp[DEPTH_LOG2] != rx_rp[DEPTH_LOG2] &&
                    rx_wp[DEPTH_LOG2-1:0] == rx_rp[DEPTH_LOG2-1:0];
        tx_cnt    = tx_wp - tx_rp;
        rx_cnt    = rx_wp - rx_rp;
        tx_valid  = !tx_empty;
        tx_data   = tx_mem[tx_rp[DEPTH_LOG2-1:0]];
        rx_ready  = !rx_full;
        tx_pop    = tx_valid && tx_ready;
        // A host pop in the same clk frees the slot, so a push at full still lands.
        tx_push   = wr_ev && off == 2'd0 && (!tx_full || tx_pop);
        tx_drop   = wr_ev && off == 2'd0 && tx_full && !tx_pop;
        rx_push   = rx_valid && rx_ready;
        // DATA reads pop on the trailing clk so rd_data holds for the whole read.
        rx_pop_ev = rd0_q && !acc;
        rx_pop    = rx_pop_ev && !rx_empty;
        rx_head   = rx_empty ? 8'h00 : rx_mem[rx_rp[DEPTH_LOG2-1:0]];
        status    = {int_en, 2'b00, rx_udf, tx_ovf, tx_empty, tx_full, !rx_empty};
        level     = {sat4(rx_cnt), sat4(tx_cnt)};
        rd_data   = !doe ? 8'h00 :
                    off == 2'd0 ? rx_head :
                    off == 2'd1 ? status :
                    off == 2'd2 ? {int_en, 7'b0} : level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= 1'b0;
            rd0_q  <= 1'b0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            acc_q  <= acc;
            rd0_q  <= doe && off == 2'd0;
            tx_wp  <= (ctrl_wr && wr_data[0]) ? '0 : tx_wp + W'(tx_push);
            tx_rp  <= (ctrl_wr && wr_data[0]) ? '0 : tx_rp + W'(tx_pop);
            rx_wp  <= (ctrl_wr && wr_data[1]) ? '0 : rx_wp + W'(rx_push);
            rx_rp  <= (ctrl_wr && wr_data[1]) ? '0 : rx_rp + W'(rx_pop);
            tx_ovf <= (tx_ovf && !(ctrl_wr && wr_data[2])) || tx_drop;
            rx_udf <= (rx_udf && !(ctrl_wr && wr_data[2])) || (rx_pop_ev && rx_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp[DEPTH_LOG2-1:0]] <= wr_data;
        if (rx_push)
            rx_mem[rx_wp[DEPTH_LOG2-1:0]] <= rx_data;
    end

`ifdef MAILBOX_INT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            int_en <= 1'b0;
            int_n  <= 1'b1;
        end else begin
            if (ctrl_wr)
                int_en <= wr_data[7];
            int_n <= !(int_en && !rx_empty);
        end
    end
`else
    assign int_en = 1'b0;
    assign int_n  = 1'b1;
`endif
endmodule

// File: tb/tb_z80_io_mailbox.sv
// tb_z80_io_mailbox: self-checking bench for z80_io_mailbox (vector table, corner sequences, random vs queue model).
module tb_z80_io_mailbox;
    logic clk = 1'b0, reset = 1'b1;
    logic iorq_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] addr = 8'h00, wr_data = 8'h00, rd_data, tx_data, rx_data = 8'h00;
    logic doe, tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, int_n;
    int vectors = 0, miscompares = 0;

    typedef struct { bit wr; logic [7:0] a; logic [7:0] d; } vec_t;
    vec_t tbl[$];
    logic [7:0] tx_q[$], rx_q[$];
    bit m_ovf, m_udf;

    z80_io_mailbox dut (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .doe(doe),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .int_n(int_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic io_out(input logic [7:0] a, input logic [7:0] d, input int n);
        addr = a; wr_data = d; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (n) cyc();
        iorq_n = 1'b1; wr_n = 1'b1;
        cyc();
    endtask

    task automatic io_in(input logic [7:0] a, output logic [7:0] d);
        addr = a; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        d = rd_data;
        check("doe_on_read", {7'b0, doe}, 8'h01);
        cyc();
        check("rd_data_stable", rd_data, d);
        iorq_n = 1'b1; rd_n = 1'b1;
        cyc();
    endtask

    task automatic in_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        io_in(a, d);
        check(name, d, exp);
    endtask

    function automatic logic [7:0] m_status();
        return {3'b000, m_udf, m_ovf, tx_q.size() == 0, tx_q.size() == 8, rx_q.size() != 0};
    endfunction

    initial begin
        logic [7:0] d;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        // Reset state
        check("reset_int_n", {7'b0, int_n}, 8'h01);
        check("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("reset_doe", {7'b0, doe}, 8'h00);
        check("reset_rd_data", rd_data, 8'h00);
        in_chk("reset_status", 8'h21, 8'h04);

        // Interrupt acknowledge and foreign ports are never decoded
        addr = 8'h21; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
        #1 check("inta_doe", {7'b0, doe}, 8'h00);
        check("inta_rd_data", rd_data, 8'h00);
        m1_n = 1'b1; addr = 8'h24;
        #1 check("foreign_doe", {7'b0, doe}, 8'h00);
        iorq_n = 1'b1; rd_n = 1'b1;
        cyc();

        // Write held for 4 clks is taken once
        io_out(8'h20, 8'hA5, 4);
        in_chk("hold_level", 8'h23, 8'h01);
        tx_ready = 1'b1;
        #1 check("hs_valid", {7'b0, tx_valid}, 8'h01);
        check("hs_data", tx_data, 8'hA5);
        cyc();
        tx_ready = 1'b0;
        check("hs_drained", {7'b0, tx_valid}, 8'h00);

        // TX overflow, flag clear and flush
        for (int i = 0; i < 9; i++) tbl.push_back('{1'b1, 8'h20, 8'(i + 1)});
        tbl.push_back('{1'b0, 8'h21, 8'h0A});
        tbl.push_back('{1'b0, 8'h23, 8'h08});
        tbl.push_back('{1'b1, 8'h22, 8'h04});
        tbl.push_back('{1'b0, 8'h21, 8'h02});
        tbl.push_back('{1'b1, 8'h22, 8'h01});
        tbl.push_back('{1'b0, 8'h21, 8'h04});
        tbl.push_back('{1'b0, 8'h23, 8'h00});
        tbl.push_back('{1'b0, 8'h22, 8'h00});
        foreach (tbl[i]) begin
            if (tbl[i].wr) io_out(tbl[i].a, tbl[i].d, 1);
            else in_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d);
        end

        // RX fill to full, drain in order, underflow
        for (int i = 1; i <= 8; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i * 17);
            cyc();
        end
        rx_valid = 1'b0;
        check("rx_full_ready", {7'b0, rx_ready}, 8'h00);
        in_chk("rx_full_level", 8'h23, 8'h80);
        for (int i = 1; i <= 8; i++) in_chk("rx_order", 8'h20, 8'(i * 17));
        in_chk("rx_udf_data", 8'h20, 8'h00);
        in_chk("rx_udf_status", 8'h21, 8'h14);
        io_out(8'h22, 8'h04, 1);
        in_chk("rx_udf_clear", 8'h21, 8'h04);

        // Interrupt
        io_out(8'h22, 8'h80, 1);
        rx_valid = 1'b1; rx_data = 8'h3C;
        cyc();
        rx_valid = 1'b0;
        check("int_latency", {7'b0, int_n}, 8'h01);
        cyc();
`ifdef MAILBOX_INT_EN
        check("int_assert", {7'b0, int_n}, 8'h00);
        in_chk("int_en_read", 8'h22, 8'h80);
        in_chk("int_data", 8'h20, 8'h3C);
        check("int_hold", {7'b0, int_n}, 8'h00);
        cyc();
        check("int_release", {7'b0, int_n}, 8'h01);
`else
        check("int_tied", {7'b0, int_n}, 8'h01);
        in_chk("int_en_read", 8'h22, 8'h00);
        in_chk("int_data", 8'h20, 8'h3C);
        check("int_tied2", {7'b0, int_n}, 8'h01);
`endif
        io_out(8'h22, 8'h00, 1);

        // CPU push and host pop in the same clk with TX full
        for (int i = 0; i < 8; i++) io_out(8'h20, 8'(8'hB0 + i), 1);
        addr = 8'h20; wr_data = 8'hC8; iorq_n = 1'b0; wr_n = 1'b0; tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
        cyc();
        in_chk("full_pp_level", 8'h23, 8'h08);
        in_chk("full_pp_status", 8'h21, 8'h02);
        for (int i = 1; i <= 8; i++) begin
            tx_ready = 1'b1;
            #1 check("full_pp_order", tx_data, i == 8 ? 8'hC8 : 8'(8'hB0 + i));
            cyc();
        end
        tx_ready = 1'b0;

        // Reset mid-write: cycle abandoned, then retaken as new
        addr = 8'h20; wr_data = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (2) cyc();
        iorq_n = 1'b1; wr_n = 1'b1;
        cyc();
        in_chk("rst_mid_level", 8'h23, 8'h01);
        check("rst_mid_data", tx_data, 8'h5A);
        io_out(8'h22, 8'h07, 1);

        // Random traffic against a queue model
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    d = 8'($urandom);
                    io_out(8'h20, d, $urandom_range(1, 3));
                    if (tx_q.size() < 8) tx_q.push_back(d); else m_ovf = 1'b1;
                end
                2: begin
                    io_in(8'h20, d);
                    if (rx_q.size() != 0) check("rnd_rx", d, rx_q.pop_front());
                    else begin check("rnd_rx_empty", d, 8'h00); m_udf = 1'b1; end
                end
                3: in_chk("rnd_status", 8'h21, m_status());
                4: in_chk("rnd_level", 8'h23, {4'(rx_q.size()), 4'(tx_q.size())});
                5: begin
                    d = 8'($urandom);
                    rx_valid = 1'b1; rx_data = d;
                    #1 check("rnd_rx_ready", {7'b0, rx_ready}, {7'b0, rx_q.size() < 8});
                    cyc();
                    rx_valid = 1'b0;
                    if (rx_q.size() < 8) rx_q.push_back(d);
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        d = 8'($urandom_range(0, 7));
                        io_out(8'h22, d, 1);
                        if (d[0]) tx_q.delete();
                        if (d[1]) rx_q.delete();
                        if (d[2]) begin m_ovf = 1'b0; m_udf = 1'b0; end
                    end else begin
                        tx_ready = 1'b1;
                        #1 check("rnd_tx_valid", {7'b0, tx_valid}, {7'b0, tx_q.size() != 0});
                        if (tx_q.size() != 0) check("rnd_tx_data", tx_data, tx_q.pop_front());
                        cyc();
                        tx_ready = 1'b0;
                    end
                end
            endcase
        end
        in_chk("rnd_final_status", 8'h21, m_status());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
